// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    // Fetch controller sequencing states
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0 -- shown on the decode bus while nothing valid has been fetched
    localparam logic [31:0] NOP = 32'h0000_0013;

    // One fetched pair as buffered between ROM and decode
    typedef struct packed {
        logic [31:0] instr0;
        logic [31:0] instr1;
        logic [31:0] pc;
        logic        v1;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: ROM read port, decode handshake and execute redirect.
// master = fetch controller side, slave = ROM / decode / execute side.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_instr1;
    logic [31:0]       rom_instr2;
    logic              dec_valid;
    logic              dec_ready;
    logic [31:0]       dec_instr0;
    logic [31:0]       dec_instr1;
    logic [31:0]       dec_pc;
    logic              dec_v1;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

    modport master (
        output rom_addr,
        input  rom_instr1, rom_instr2,
        output dec_valid, dec_instr0, dec_instr1, dec_pc, dec_v1,
        input  dec_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  rom_addr,
        output rom_instr1, rom_instr2,
        input  dec_valid, dec_instr0, dec_instr1, dec_pc, dec_v1,
        output dec_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO of fetched pairs. The caller never pushes when full and
// never pops when empty; flush drops all contents in one cycle.
module fetch_fifo2
    import fetch_ctrl_pkg::*;
#(
    parameter fetch_pair_t RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  fetch_pair_t din,
    input  logic        pop,
    output fetch_pair_t dout,
    output logic [1:0]  count
);
    fetch_pair_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    // Storage, pointers and occupancy; a push and pop together keep the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= RST_VAL;
            mem[1] <= RST_VAL;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues two-word reads to a dual-read ROM,
// buffers returned pairs in a 2-entry FIFO and hands them to decode.
// Define FETCH_PERF_EN to add the perf_pairs / perf_stalls counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_ctrl_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_pairs,
    output logic [31:0]      perf_stalls
`endif
);
    localparam logic [ADDR_W-1:0] IDX_MAX = '1;
    localparam fetch_pair_t RST_PAIR = '{instr0: NOP, instr1: NOP, pc: RESET_PC, v1: 1'b0};

    fetch_state_t      state, state_nxt;
    logic              flush, issue_en, issue;
    logic              xfer, pop, push;
    logic [31:0]       pc, pc_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              inflight;
    logic [31:0]       inflight_pc;
    logic              inflight_v1;
    logic [1:0]        occ;
    logic [2:0]        level;
    fetch_pair_t       head, wr_pair;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RESET;
        else        state <= state_nxt;
    end

    // FSM next state: one FILL cycle after reset, then RUN; a redirect passes through FLUSH
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = ST_FILL;
            ST_FILL:  state_nxt = bus.redirect_valid ? ST_FLUSH : ST_RUN;
            ST_RUN:   state_nxt = bus.redirect_valid ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_nxt = bus.redirect_valid ? ST_FLUSH : ST_RUN;
            default:  state_nxt = ST_RESET;
        endcase
    end

    // FSM outputs: a redirect flushes the pipe in any state and blocks issue that cycle
    // so the next read goes to the redirect target; issue is otherwise credit-limited
    always_comb begin
        flush    = bus.redirect_valid;
        issue_en = !bus.redirect_valid;
    end

    assign idx          = pc[ADDR_W+1:2];
    assign bus.rom_addr = idx;

    // The pair leaving this cycle frees a slot, so count it to sustain one pair per cycle
    assign xfer  = bus.dec_valid && bus.dec_ready;
    assign pop   = xfer && !flush;
    assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue = issue_en && (level < 3'd2);

    // Last word index wraps the PC back to zero; an odd index simply steps by two
    assign idx_nxt = (idx == IDX_MAX) ? '0 : idx + ADDR_W'(2);
    assign pc_nxt  = {pc[31:ADDR_W+2], idx_nxt, 2'b00};

    // PC and single in-flight read tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            inflight_v1 <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                inflight_v1 <= (idx != IDX_MAX);
            end
            if (flush) begin
                pc <= bus.redirect_pc & ~32'd3;
            end else if (issue) begin
                pc <= pc_nxt;
            end
        end
    end

    // ROM data arrives the cycle after issue; a flush discards it
    assign push    = inflight && !flush;
    assign wr_pair = '{instr0: bus.rom_instr1, instr1: bus.rom_instr2,
                       pc: inflight_pc, v1: inflight_v1};

    fetch_fifo2 #(
        .RST_VAL (RST_PAIR)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (wr_pair),
        .pop   (pop),
        .dout  (head),
        .count (occ)
    );

    assign bus.dec_valid  = (occ != 2'd0);
    assign bus.dec_instr0 = head.instr0;
    assign bus.dec_instr1 = head.instr1;
    assign bus.dec_pc     = head.pc;
    assign bus.dec_v1     = head.v1;

`ifdef FETCH_PERF_EN
    // Saturating transfer and stall counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_pairs  <= '0;
            perf_stalls <= '0;
        end else begin
            if (xfer && (perf_pairs != '1)) begin
                perf_pairs <= perf_pairs + 32'd1;
            end
            if (bus.dec_valid && !bus.dec_ready && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: ROM model, scoreboard of expected pairs,
// directed checks on latency, stall, redirect, wrap and reset.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_xfer = 0;
    int   n_stall = 0;

    fetch_pair_t sb[$];
    logic        hold_armed = 1'b0;
    logic [31:0] hold_pc, hold_i0;

    fetch_ctrl_if #(.ADDR_W(10)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_pairs, perf_stalls;
`endif

    fetch_ctrl #(.ADDR_W(10), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_pairs  (perf_pairs),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romval(input logic [9:0] i);
        return {16'hC0DE, 6'd0, i};
    endfunction

    // Dual-read ROM with one cycle of latency
    always @(posedge clk) begin
        bus.rom_instr1 <= romval(bus.rom_addr);
        bus.rom_instr2 <= romval(bus.rom_addr + 10'd1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] p;
        logic [9:0]  i;
        p = start & ~32'd3;
        for (int k = 0; k < n; k++) begin
            fetch_pair_t e;
            i        = p[11:2];
            e.pc     = p;
            e.instr0 = romval(i);
            e.instr1 = romval(i + 10'd1);
            e.v1     = (i != 10'h3FF);
            sb.push_back(e);
            p = (i == 10'h3FF) ? 32'h0 : {p[31:12], i + 10'd2, 2'b00};
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dec_valid", bus.dec_valid, 0);
        chk("rst_dec_v1", bus.dec_v1, 0);
        chk("rst_instr0", bus.dec_instr0, NOP);
        chk("rst_instr1", bus.dec_instr1, NOP);
        chk("rst_dec_pc", bus.dec_pc, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_pairs", perf_pairs, 0);
        chk("rst_perf_stalls", perf_stalls, 0);
`endif
    endtask

    // Scoreboard monitor and hold-stability check, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_armed && bus.dec_valid) begin
                chk("hold_pc", bus.dec_pc, hold_pc);
                chk("hold_instr0", bus.dec_instr0, hold_i0);
            end
            hold_armed = bus.dec_valid && !bus.dec_ready && !bus.redirect_valid;
            hold_pc    = bus.dec_pc;
            hold_i0    = bus.dec_instr0;
            if (bus.dec_valid && !bus.dec_ready) n_stall++;
            if (bus.dec_valid && bus.dec_ready) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    chk("sb_pending", 64'(sb.size()), 1);
                end else begin
                    fetch_pair_t e;
                    e = sb.pop_front();
                    chk("sb_pc", bus.dec_pc, e.pc);
                    chk("sb_instr0", bus.dec_instr0, e.instr0);
                    chk("sb_v1", bus.dec_v1, e.v1);
                    if (e.v1) chk("sb_instr1", bus.dec_instr1, e.instr1);
                end
            end
        end else begin
            hold_armed = 1'b0;
        end
    end

    initial begin
        rst_n              = 1'b0;
        bus.dec_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (3) cyc();
        chk_reset_outputs();

        // Reset release with decode ready: fetch 0,2,4... and first pair two edges later
        push_stream(32'h0, 40);
        rst_n         = 1'b1;
        bus.dec_ready = 1'b1;
        chk("c0_rom_addr", bus.rom_addr, 0);
        cyc(); chk("c1_rom_addr", bus.rom_addr, 2); chk("c1_dec_valid", bus.dec_valid, 0);
        cyc(); chk("c2_rom_addr", bus.rom_addr, 4); chk("c2_dec_valid", bus.dec_valid, 1);
               chk("c2_dec_pc", bus.dec_pc, 32'h0);
        cyc(); chk("c3_dec_pc", bus.dec_pc, 32'h8);  chk("c3_rom_addr", bus.rom_addr, 6);
        cyc(); chk("c4_dec_pc", bus.dec_pc, 32'h10);

        // Decode stalls at pc 16 for five cycles, then resumes in order
        bus.dec_ready = 1'b0;
        repeat (5) begin
            cyc();
            chk("stall_dec_valid", bus.dec_valid, 1);
            chk("stall_dec_pc", bus.dec_pc, 32'h10);
        end
        bus.dec_ready = 1'b1;
        cyc(); chk("resume_pc0", bus.dec_pc, 32'h18);
        cyc(); chk("resume_pc1", bus.dec_pc, 32'h20);

        // Fill the FIFO, then redirect to 0x40 while full
        bus.dec_ready = 1'b0;
        repeat (3) cyc();
        chk("full_dec_pc", bus.dec_pc, 32'h20);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        cyc();
        bus.redirect_valid = 1'b0;
        sb.delete();
        push_stream(32'h40, 16);
        chk("rdr_dec_valid", bus.dec_valid, 0);
        chk("rdr_rom_addr", bus.rom_addr, 16);
        bus.dec_ready = 1'b1;
        cyc(); chk("rdr_lat_valid", bus.dec_valid, 0);
        cyc(); chk("rdr_first_valid", bus.dec_valid, 1); chk("rdr_first_pc", bus.dec_pc, 32'h40);
        cyc(); chk("rdr_second_pc", bus.dec_pc, 32'h48);

        // Redirect to the last word (low bits set) together with a transfer
        chk("rdr_xfer_valid", bus.dec_valid, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFE;
        cyc();
        bus.redirect_valid = 1'b0;
        sb.delete();
        push_stream(32'hFFC, 16);
        chk("wrap_dec_valid", bus.dec_valid, 0);
        chk("wrap_rom_addr", bus.rom_addr, 10'h3FF);
        cyc();
        cyc(); chk("wrap_pc", bus.dec_pc, 32'hFFC); chk("wrap_v1", bus.dec_v1, 0);
               chk("wrap_instr0", bus.dec_instr0, romval(10'h3FF));
        cyc(); chk("wrap_next_pc", bus.dec_pc, 32'h0); chk("wrap_next_v1", bus.dec_v1, 1);
        cyc();
`ifdef FETCH_PERF_EN
        chk("perf_pairs", perf_pairs, 32'(n_xfer));
        chk("perf_stalls", perf_stalls, 32'(n_stall));
`endif

        // Reset in the middle of a running stream
        rst_n   = 1'b0;
        n_xfer  = 0;
        n_stall = 0;
        sb.delete();
        cyc();
        chk_reset_outputs();
        push_stream(32'h0, 8);
        rst_n = 1'b1;
        cyc();
        cyc(); chk("rerun_valid", bus.dec_valid, 1); chk("rerun_pc", bus.dec_pc, 32'h0);
        cyc(); chk("rerun_pc1", bus.dec_pc, 32'h8);
        bus.dec_ready = 1'b0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
